// File: rtl/hdr_parse_sched_pkg.sv
// Shared packet-header types, field offsets and byte-extraction helper.
package hdr_parse_sched_pkg;

  localparam int unsigned HDR_W = 512;

  typedef enum logic [1:0] {
    L3_OTHER = 2'd0,
    L3_IPV4  = 2'd1,
    L3_IPV6  = 2'd2
  } l3_type;

  typedef struct packed {
    l3_type        l3;
    logic [15:0]   eth_type;
    logic [7:0]    proto;
    logic [127:0]  src_ip;
    logic [127:0]  dst_ip;
    logic          l4_valid;
    logic [15:0]   src_port;
    logic [15:0]   dst_port;
  } hdr_info_t;

  // Byte offsets within the first beat; byte b lives at bits [511-8b -: 8].
  localparam int unsigned OFF_ETH_TYPE = 12;
  localparam int unsigned OFF_IP_VER   = 14;
  localparam int unsigned OFF_V4_FRAG  = 20;
  localparam int unsigned OFF_V4_PROTO = 23;
  localparam int unsigned OFF_V4_SRC   = 26;
  localparam int unsigned OFF_V4_DST   = 30;
  localparam int unsigned OFF_V4_SPORT = 34;
  localparam int unsigned OFF_V4_DPORT = 36;
  localparam int unsigned OFF_V6_NH    = 20;
  localparam int unsigned OFF_V6_SRC   = 22;
  localparam int unsigned OFF_V6_DST   = 38;
  localparam int unsigned OFF_V6_SPORT = 54;
  localparam int unsigned OFF_V6_DPORT = 56;

  localparam logic [15:0] ETH_IPV4  = 16'h0800;
  localparam logic [15:0] ETH_IPV6  = 16'h86DD;
  localparam logic [7:0]  PROTO_TCP = 8'd6;
  localparam logic [7:0]  PROTO_UDP = 8'd17;

  // Concatenate n big-endian bytes starting at byte off, right-aligned.
  function automatic logic [127:0] hdr_bytes(input logic [HDR_W-1:0] h,
                                             input int unsigned off,
                                             input int unsigned n);
    logic [127:0] r;
    logic [8:0]   lsb;
    r = '0;
    for (int unsigned i = 0; i < n; i++) begin
      lsb = 9'(HDR_W - 8 - 8 * (off + i));
      r   = {r[119:0], h[lsb +: 8]};
    end
    return r;
  endfunction

endpackage

// File: rtl/hdr_field_extract.sv
// Combinational L2/L3/L4 field extraction with one output register.
module hdr_field_extract
  import hdr_parse_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [HDR_W-1:0] hdr,
  output hdr_info_t        info
);

  hdr_info_t   info_c;
  hdr_info_t   info_d;
  hdr_info_t   info_q;
  logic [15:0] eth;
  logic [7:0]  ver_ihl;
  logic [12:0] frag_off;

  // Classify the beat and pull out the fields; unclassified frames give zeros.
  always_comb begin
    info_c          = '0;
    eth             = 16'(hdr_bytes(hdr, OFF_ETH_TYPE, 2));
    ver_ihl         = 8'(hdr_bytes(hdr, OFF_IP_VER, 1));
    frag_off        = 13'(hdr_bytes(hdr, OFF_V4_FRAG, 2));
    info_c.eth_type = eth;
    if (eth == ETH_IPV4 && ver_ihl[7:4] == 4'd4) begin
      info_c.l3     = L3_IPV4;
      info_c.proto  = 8'(hdr_bytes(hdr, OFF_V4_PROTO, 1));
      info_c.src_ip = hdr_bytes(hdr, OFF_V4_SRC, 4);
      info_c.dst_ip = hdr_bytes(hdr, OFF_V4_DST, 4);
      // Options or fragments move/hide the L4 header, so ports are only trusted on plain first fragments.
      if (ver_ihl[3:0] == 4'd5 && frag_off == 13'd0 &&
          (info_c.proto == PROTO_TCP || info_c.proto == PROTO_UDP)) begin
        info_c.l4_valid = 1'b1;
        info_c.src_port = 16'(hdr_bytes(hdr, OFF_V4_SPORT, 2));
        info_c.dst_port = 16'(hdr_bytes(hdr, OFF_V4_DPORT, 2));
      end
    end else if (eth == ETH_IPV6 && ver_ihl[7:4] == 4'd6) begin
      info_c.l3     = L3_IPV6;
      info_c.proto  = 8'(hdr_bytes(hdr, OFF_V6_NH, 1));
      info_c.src_ip = hdr_bytes(hdr, OFF_V6_SRC, 16);
      info_c.dst_ip = hdr_bytes(hdr, OFF_V6_DST, 16);
      if (info_c.proto == PROTO_TCP || info_c.proto == PROTO_UDP) begin
        info_c.l4_valid = 1'b1;
        info_c.src_port = 16'(hdr_bytes(hdr, OFF_V6_SPORT, 2));
        info_c.dst_port = 16'(hdr_bytes(hdr, OFF_V6_DPORT, 2));
      end
    end
    info_d = en ? info_c : info_q;
  end

  // Result register; holds its value until the next parse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) info_q <= '0;
    else        info_q <= info_d;
  end

  assign info = info_q;

endmodule

// File: rtl/hdr_parse_sched.sv
// Round-robin scheduler sharing one header field extractor among requesters.
module hdr_parse_sched
  import hdr_parse_sched_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                        axis_aclk,
  input  logic                        box_rstn,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS*DATA_W-1:0] req_hdr,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [NUM_PORTS-1:0]        res_valid,
  input  logic [NUM_PORTS-1:0]        res_ready,
  output logic [1:0]                  res_l3,
  output logic [15:0]                 res_eth_type,
  output logic [7:0]                  res_proto,
  output logic [127:0]                res_src_ip,
  output logic [127:0]                res_dst_ip,
  output logic                        res_l4_valid,
  output logic [15:0]                 res_src_port,
  output logic [15:0]                 res_dst_port,
  output logic                        busy,
  output logic [31:0]                 drop_cnt
);

  localparam int unsigned GW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {ST_IDLE, ST_PARSE, ST_RESP} state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [DATA_W-1:0]  hdr_q, hdr_d;
  logic [31:0]        wait_cnt_q, wait_cnt_d;
  logic [31:0]        drop_cnt_q, drop_cnt_d;
  logic [GW-1:0]      pick_c;
  logic               found_c;
  logic               parse_en_c;
  logic [NUM_PORTS-1:0] req_ready_c;
  logic [NUM_PORTS-1:0] res_valid_c;
  int unsigned        idx;
  hdr_info_t          info;

  // Round-robin search starting just after the last granted port.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found_c && req_valid[GW'(idx)]) begin
        found_c = 1'b1;
        pick_c  = GW'(idx);
      end
    end
  end

  // Next-state, capture and timeout/drop accounting.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hdr_d        = hdr_q;
    wait_cnt_d   = wait_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    parse_en_c   = 1'b0;
    req_ready_c  = '0;
    case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          req_ready_c[pick_c] = 1'b1;
          for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (pick_c == GW'(i)) hdr_d = req_hdr[i*DATA_W +: DATA_W];
          end
          last_grant_d = pick_c;
          state_d      = ST_PARSE;
        end
      end
      ST_PARSE: begin
        parse_en_c = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        wait_cnt_d = wait_cnt_q + 32'd1;
        // A handshake in the timeout cycle still counts as a normal completion.
        if (res_ready[last_grant_q]) begin
          state_d = ST_IDLE;
        end else if (TIMEOUT_CYC != 0 && wait_cnt_d == TIMEOUT_CYC) begin
          state_d    = ST_IDLE;
          drop_cnt_d = (drop_cnt_q == 32'hFFFF_FFFF) ? drop_cnt_q : drop_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and bookkeeping registers; reset discards any in-flight result.
  always_ff @(posedge axis_aclk or negedge box_rstn) begin
    if (!box_rstn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GW'(NUM_PORTS - 1);
      hdr_q        <= '0;
      wait_cnt_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hdr_q        <= hdr_d;
      wait_cnt_q   <= wait_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // One-hot result valid decoded from the registered state and grant.
  always_comb begin
    res_valid_c = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      res_valid_c[i] = (state_q == ST_RESP) && (last_grant_q == GW'(i));
    end
  end

  hdr_field_extract u_extract (
    .clk   (axis_aclk),
    .rst_n (box_rstn),
    .en    (parse_en_c),
    .hdr   (hdr_q),
    .info  (info)
  );

  assign req_ready    = box_rstn ? req_ready_c : '0;
  assign res_valid    = res_valid_c;
  assign res_l3       = info.l3;
  assign res_eth_type = info.eth_type;
  assign res_proto    = info.proto;
  assign res_src_ip   = info.src_ip;
  assign res_dst_ip   = info.dst_ip;
  assign res_l4_valid = info.l4_valid;
  assign res_src_port = info.src_port;
  assign res_dst_port = info.dst_port;
  assign busy         = (state_q != ST_IDLE);
  assign drop_cnt     = drop_cnt_q;

endmodule
